wb_trace_fifo: RTL and testbench

//  Write-back trace buffer downstream of the CPU top level.

---
 rtl/wb_trace_fifo.sv | 116 +++++++++++
 tb/tb_wb_trace_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: write-back trace buffer.
// Captures CPU register write-back events (address, data) in a show-ahead FIFO
// and hands them to a slow consumer over a valid/ready handshake. An optional
// per-register shadow table drops writes that do not change the last traced value.
module wb_trace_fifo #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FILTER_DUP = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [ADDR_W-1:0]          i_write_add,
    input  logic [DATA_W-1:0]          i_write_data,
    input  logic                       i_clear,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [ADDR_W-1:0]          o_add,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [7:0]                 o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REGS  = 2 ** ADDR_W;

    // Entry storage and shadow data carry no reset; validity lives in control state.
    logic [ADDR_W-1:0] mem_add  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DATA_W-1:0] shadow   [REGS];
    logic [REGS-1:0]   shadow_v;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    logic              pop;
    logic              dup;
    logic              cand;
    logic              push;
    logic              drop;

    assign o_empty    = (count == '0);
    assign o_full     = (count == CNT_W'(DEPTH));
    assign o_valid    = ~o_empty;
    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_drop_cnt = drop_cnt;

    // Head entry shown combinationally, zeroed while nothing is held.
    assign o_add  = o_valid ? mem_add[rd_ptr]  : '0;
    assign o_data = o_valid ? mem_data[rd_ptr] : '0;

    assign pop  = o_valid & i_ready;
    assign dup  = (FILTER_DUP != 0) & shadow_v[i_write_add]
                  & (shadow[i_write_add] == i_write_data);
    assign cand = i_valid & ~dup;
    // When full, a simultaneous pop frees the head slot, which is the write slot.
    assign push = cand & (~o_full | pop);
    assign drop = cand & o_full & ~pop;

    // Control state: pointers, occupancy, overflow tracking, shadow validity.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
            shadow_v <= '0;
        end else if (i_clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
            shadow_v <= '0;
        end else begin
            if (push) begin
                wr_ptr                <= wr_ptr + PTR_W'(1);
                shadow_v[i_write_add] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Data path: store accepted entries and remember the last traced value per register.
    always_ff @(posedge i_clk) begin
        if (push && !i_clear) begin
            mem_add[wr_ptr]      <= i_write_add;
            mem_data[wr_ptr]     <= i_write_data;
            shadow[i_write_add]  <= i_write_data;
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed stimulus with a scoreboard queue of expected
// head entries, drained by an independent monitor on the consumer handshake.
module tb_wb_trace_fifo;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic [3:0] i_write_add;
    logic [7:0] i_write_data;
    logic       i_clear;
    logic       i_ready;

    logic       o_valid,  o_full,  o_empty,  o_overflow;
    logic [3:0] o_add;
    logic [7:0] o_data,   o_drop_cnt;
    logic [3:0] o_count;

    logic       n_valid,  n_full,  n_empty,  n_overflow;
    logic [3:0] n_add;
    logic [7:0] n_data,   n_drop_cnt;
    logic [3:0] n_count;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(8), .ADDR_W(4), .DATA_W(8), .FILTER_DUP(1)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_write_add(i_write_add),
        .i_write_data(i_write_data), .i_clear(i_clear), .i_ready(i_ready),
        .o_valid(o_valid), .o_add(o_add), .o_data(o_data), .o_count(o_count),
        .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
    );

    wb_trace_fifo #(.DEPTH(8), .ADDR_W(4), .DATA_W(8), .FILTER_DUP(0)) dut_nf (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_write_add(i_write_add),
        .i_write_data(i_write_data), .i_clear(i_clear), .i_ready(i_ready),
        .o_valid(n_valid), .o_add(n_add), .o_data(n_data), .o_count(n_count),
        .o_full(n_full), .o_empty(n_empty), .o_overflow(n_overflow), .o_drop_cnt(n_drop_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every handshake about to complete must match the scoreboard head.
    always @(negedge clk) begin
        if (i_reset && !i_clear && o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got add=%0h data=%0h, expected nothing", o_add, o_data);
            end else begin
                if ({o_add, o_data} != exp_q[0]) begin
                    bad++;
                    $display("FAIL out_order: got add=%0h data=%0h expected add=%0h data=%0h",
                             o_add, o_data, exp_q[0][11:8], exp_q[0][7:0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock: apply inputs, then return 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [3:0] a, input logic [7:0] d,
                       input logic r, input logic c);
        i_valid = v; i_write_add = a; i_write_data = d; i_ready = r; i_clear = c;
        @(posedge clk); #1;
    endtask

    // Issue one write-back; acc says whether the filtered FIFO should trace it.
    task automatic ev(input logic [3:0] a, input logic [7:0] d, input logic r, input bit acc);
        cyc(1'b1, a, d, r, 1'b0);
        if (acc) exp_q.push_back({a, d});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((!o_empty || !n_empty) && n < 40) begin
            cyc(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk({name, "_drained"}, int'(o_empty && n_empty), 1);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_write_add = '0; i_write_data = '0;
        i_clear = 1'b0; i_ready = 1'b0;
        #23;
        // Reset state while asserted and just after release.
        chk("rst_valid", o_valid, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_add", o_add, 0);
        chk("rst_data", o_data, 0);
        chk("rst_count", o_count, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_drop", o_drop_cnt, 0);
        i_reset = 1'b1;
        @(posedge clk); #1;

        // 1: two events through a ready consumer, count 0,1,1,0.
        ev(4'd3, 8'h11, 1'b1, 1);
        chk("t1_count_a", o_count, 1);
        chk("t1_valid_a", o_valid, 1);
        ev(4'd4, 8'h22, 1'b1, 1);
        chk("t1_count_b", o_count, 1);
        cyc(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        chk("t1_count_c", o_count, 0);
        chk("t1_empty", o_empty, 1);
        i_ready = 1'b0;

        // 2: stalled consumer, ten events into eight slots.
        for (int i = 0; i < 10; i++) begin
            ev(4'(i), 8'(8'h30 + i), 1'b0, i < 8);
            if (i == 7) begin
                chk("t2_full", o_full, 1);
                chk("t2_count8", o_count, 8);
                chk("t2_nodrop_yet", o_drop_cnt, 0);
            end
        end
        chk("t2_drop_cnt", o_drop_cnt, 2);
        chk("t2_overflow", o_overflow, 1);
        chk("t2_count", o_count, 8);
        drain("t2");
        chk("t2_ovf_sticky", o_overflow, 1);
        cyc(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        chk("t2_clr_ovf", o_overflow, 0);
        chk("t2_clr_drop", o_drop_cnt, 0);

        // 3: duplicate filter against an unfiltered instance.
        ev(4'd5, 8'h7A, 1'b0, 1);
        ev(4'd5, 8'h7A, 1'b0, 0);
        ev(4'd5, 8'h7B, 1'b0, 1);
        chk("t3_filt_count", o_count, 2);
        chk("t3_nofilt_count", n_count, 3);
        chk("t3_dup_not_drop", o_drop_cnt, 0);
        drain("t3");

        // 4: full plus same-cycle push/pop, over three fills to wrap pointers.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) ev(4'(i), 8'(8'h80 + 16 * f + i), 1'b0, 1);
            chk("t4_full", o_full, 1);
            ev(4'd8, 8'(8'hE0 + f), 1'b1, 1);
            chk("t4_count_stays", o_count, 8);
            chk("t4_no_drop", o_drop_cnt, 0);
            drain("t4");
        end

        // 5: clear overrides push and pop; shadow validity is forgotten.
        ev(4'd5, 8'h7A, 1'b0, 1);
        for (int i = 0; i < 8; i++) ev(4'(8 + i), 8'(8'h40 + i), 1'b0, i < 7);
        chk("t5_pre_drop", o_drop_cnt, 1);
        chk("t5_pre_ovf", o_overflow, 1);
        cyc(1'b1, 4'd6, 8'h66, 1'b1, 1'b1);
        exp_q.delete();
        chk("t5_clr_count", o_count, 0);
        chk("t5_clr_ovf", o_overflow, 0);
        chk("t5_clr_drop", o_drop_cnt, 0);
        chk("t5_clr_empty", o_empty, 1);
        ev(4'd5, 8'h7A, 1'b0, 1);
        chk("t5_retrace", o_count, 1);
        ev(4'd5, 8'h7A, 1'b0, 0);
        chk("t5_dup_again", o_count, 1);
        drain("t5");

        // 6: asynchronous reset between edges in the middle of a burst.
        ev(4'd1, 8'hA1, 1'b0, 1);
        ev(4'd2, 8'hA2, 1'b0, 1);
        ev(4'd3, 8'hA3, 1'b0, 1);
        i_valid = 1'b1; i_write_add = 4'd4; i_write_data = 8'hA4;
        #2 i_reset = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_valid", o_valid, 0);
        chk("t6_count", o_count, 0);
        chk("t6_empty", o_empty, 1);
        chk("t6_add", o_add, 0);
        chk("t6_data", o_data, 0);
        i_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_count", o_count, 0);
        ev(4'd2, 8'hA2, 1'b0, 1);
        chk("t6_alive", o_count, 1);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
